// File: rtl/fpmul_initiator_if.sv
// Operand and result valid/ready channels between the initiator and the FP multiplier.
interface fpmul_initiator_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] res_data_i;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output a, b, in_valid, res_ready,
    input  in_ready, res_data_i, res_valid
  );

  modport slave (
    input  a, b, in_valid, res_ready,
    output in_ready, res_data_i, res_valid
  );
endinterface

// File: rtl/fpmul_initiator.sv
// Initiator engine for the FP multiplier: buffers operand pairs, issues them one at a time,
// collects products into a first-word fall-through result FIFO, counts traffic and flags errors.
module fpmul_initiator #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_push,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              op_full,
  output logic              ovf,
  fpmul_initiator_if.master mif,
  input  logic              res_pop,
  output logic [DATA_W-1:0] res_data,
  output logic              res_empty,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  done_cnt,
  output logic              busy,
  output logic              proto_err
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RES
  } state_t;

  state_t r_state;

  logic [2*DATA_W-1:0] r_op_mem [DEPTH];
  ptr_t                r_op_wr;
  ptr_t                r_op_rd;
  cnt_t                r_op_cnt;

  logic [DATA_W-1:0]   r_res_mem [DEPTH];
  ptr_t                r_res_wr;
  ptr_t                r_res_rd;
  cnt_t                r_res_cnt;

  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_in_valid;
  logic [CNT_W-1:0]    r_issued_cnt;
  logic [CNT_W-1:0]    r_done_cnt;
  logic                r_ovf;
  logic                r_proto_err;

  logic                w_op_full;
  logic                w_op_empty;
  logic                w_op_wr;
  logic                w_op_rd;
  logic [2*DATA_W-1:0] w_op_head;
  logic                w_res_full;
  logic                w_res_empty;
  logic                w_res_ready;
  logic                w_res_wr;
  logic                w_res_rd;

  assign w_op_full   = (r_op_cnt == FULL_CNT);
  assign w_op_empty  = (r_op_cnt == '0);
  assign w_op_wr     = op_push && !w_op_full;
  assign w_op_rd     = (r_state == ISSUE) && mif.in_ready;
  assign w_op_head   = r_op_mem[r_op_rd];

  assign w_res_full  = (r_res_cnt == FULL_CNT);
  assign w_res_empty = (r_res_cnt == '0);
  assign w_res_ready = (r_state == WAIT_RES) && !w_res_full;
  assign w_res_wr    = w_res_ready && mif.res_valid;
  assign w_res_rd    = res_pop && !w_res_empty;

  // Storage arrays carry no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (w_op_wr) r_op_mem[r_op_wr] <= {op_a, op_b};
    if (w_res_wr) r_res_mem[r_res_wr] <= mif.res_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_wr   <= '0;
      r_op_rd   <= '0;
      r_op_cnt  <= '0;
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_op_wr) r_op_wr <= r_op_wr + ptr_t'(1);
      if (w_op_rd) r_op_rd <= r_op_rd + ptr_t'(1);
      case ({w_op_wr, w_op_rd})
        2'b10:   r_op_cnt <= r_op_cnt + cnt_t'(1);
        2'b01:   r_op_cnt <= r_op_cnt - cnt_t'(1);
        default: r_op_cnt <= r_op_cnt;
      endcase

      if (w_res_wr) r_res_wr <= r_res_wr + ptr_t'(1);
      if (w_res_rd) r_res_rd <= r_res_rd + ptr_t'(1);
      case ({w_res_wr, w_res_rd})
        2'b10:   r_res_cnt <= r_res_cnt + cnt_t'(1);
        2'b01:   r_res_cnt <= r_res_cnt - cnt_t'(1);
        default: r_res_cnt <= r_res_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_in_valid   <= 1'b0;
      r_issued_cnt <= '0;
      r_done_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      if (op_push && w_op_full) r_ovf <= 1'b1;
      // A product offered outside WAIT_RES is never accepted, only flagged.
      if (mif.res_valid && (r_state != WAIT_RES)) r_proto_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (!w_op_empty) begin
            r_a        <= w_op_head[2*DATA_W-1:DATA_W];
            r_b        <= w_op_head[DATA_W-1:0];
            r_in_valid <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mif.in_ready) begin
            r_in_valid   <= 1'b0;
            r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            r_state      <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (w_res_wr) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
            r_state    <= IDLE;
          end
        end
        default: begin
          r_in_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign mif.a         = r_a;
  assign mif.b         = r_b;
  assign mif.in_valid  = r_in_valid;
  assign mif.res_ready = w_res_ready;

  assign op_full    = w_op_full;
  assign ovf        = r_ovf;
  assign res_data   = w_res_empty ? '0 : r_res_mem[r_res_rd];
  assign res_empty  = w_res_empty;
  assign issued_cnt = r_issued_cnt;
  assign done_cnt   = r_done_cnt;
  assign busy       = (r_state != IDLE) || !w_op_empty;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_fpmul_initiator.sv
// Scoreboard bench for fpmul_initiator; the bench plays both host and multiplier.
module tb_fpmul_initiator;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              op_push;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_full;
  logic              ovf;
  logic              res_pop;
  logic [DATA_W-1:0] res_data;
  logic              res_empty;
  logic [CNT_W-1:0]  issued_cnt;
  logic [CNT_W-1:0]  done_cnt;
  logic              busy;
  logic              proto_err;

  fpmul_initiator_if #(.DATA_W(DATA_W)) mif ();

  fpmul_initiator #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .op_push   (op_push),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_full   (op_full),
    .ovf       (ovf),
    .mif       (mif),
    .res_pop   (res_pop),
    .res_data  (res_data),
    .res_empty (res_empty),
    .issued_cnt(issued_cnt),
    .done_cnt  (done_cnt),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*DATA_W-1:0] q_issue [$];
  logic [DATA_W-1:0]   q_res   [$];
  int                  m_opcnt  = 0;
  int                  m_rescnt = 0;
  logic [CNT_W-1:0]    m_issued = '0;
  logic [CNT_W-1:0]    m_done   = '0;
  logic [DATA_W-1:0]   cur_a, cur_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference products for the IEEE-754 vectors used; other pairs get a reversible scramble.
  function automatic logic [DATA_W-1:0] fmul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    case ({x, y})
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;
      {32'hBF80_0000, 32'h4000_0000}: return 32'hC000_0000;
      {32'h0000_0000, 32'h4000_0000}: return 32'h0000_0000;
      default:                        return x ^ {y[15:0], y[31:16]};
    endcase
  endfunction

  task automatic push(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    chk("op_full", op_full, (m_opcnt == DEPTH));
    op_push = 1'b1;
    op_a    = x;
    op_b    = y;
    if (m_opcnt < DEPTH) begin
      q_issue.push_back({x, y});
      m_opcnt++;
    end
    tick();
    op_push = 1'b0;
  endtask

  task automatic serve_issue(input int hold);
    logic [2*DATA_W-1:0] exp;
    int n;
    n = 0;
    while (!mif.in_valid && n < 40) begin
      tick();
      n++;
    end
    chk("in_valid_wait", mif.in_valid, 1'b1);
    repeat (hold) tick();
    exp   = (q_issue.size() > 0) ? q_issue.pop_front() : '0;
    cur_a = exp[2*DATA_W-1:DATA_W];
    cur_b = exp[DATA_W-1:0];
    chk("op_a", mif.a, cur_a);
    chk("op_b", mif.b, cur_b);
    chk("in_valid_hold", mif.in_valid, 1'b1);
    mif.in_ready = 1'b1;
    tick();
    mif.in_ready = 1'b0;
    m_opcnt--;
    m_issued++;
    chk("in_valid_drop", mif.in_valid, 1'b0);
    chk("issued_cnt", issued_cnt, m_issued);
    chk("res_ready_entry", mif.res_ready, (m_rescnt < DEPTH));
  endtask

  task automatic present();
    mif.res_valid  = 1'b1;
    mif.res_data_i = fmul(cur_a, cur_b);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!mif.res_ready && n < 40) begin
      tick();
      n++;
    end
    chk("res_ready_wait", mif.res_ready, 1'b1);
    tick();
    q_res.push_back(mif.res_data_i);
    mif.res_valid  = 1'b0;
    mif.res_data_i = '0;
    m_rescnt++;
    m_done++;
    chk("done_cnt", done_cnt, m_done);
    chk("res_ready_fall", mif.res_ready, 1'b0);
    chk("res_empty_after_wr", res_empty, 1'b0);
  endtask

  task automatic serve(input int lat, input int hold);
    serve_issue(hold);
    repeat (lat) tick();
    present();
    wait_accept();
  endtask

  task automatic pop_one();
    logic [DATA_W-1:0] exp;
    chk("res_empty", res_empty, (m_rescnt == 0));
    if (m_rescnt > 0) begin
      exp = q_res.pop_front();
      chk("res_data", res_data, exp);
      m_rescnt--;
    end
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_op_full", op_full, 1'b0);
    chk("rst_res_empty", res_empty, 1'b1);
    chk("rst_res_data", res_data, '0);
    chk("rst_a", mif.a, '0);
    chk("rst_b", mif.b, '0);
    chk("rst_in_valid", mif.in_valid, 1'b0);
    chk("rst_res_ready", mif.res_ready, 1'b0);
    chk("rst_issued", issued_cnt, '0);
    chk("rst_done", done_cnt, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_proto", proto_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_push = 1'b0; op_a = '0; op_b = '0; res_pop = 1'b0;
    mif.in_ready = 1'b0; mif.res_valid = 1'b0; mif.res_data_i = '0;
    tick();
    tick();
    check_reset_state();
    rst = 1'b0;
    tick();

    // Single transaction with push-to-issue timing
    push(32'h4000_0000, 32'h4040_0000);
    chk("push_iv_lat0", mif.in_valid, 1'b0);
    chk("busy_queued", busy, 1'b1);
    tick();
    chk("push_iv_lat1", mif.in_valid, 1'b1);
    serve(2, 0);
    chk("busy_idle", busy, 1'b0);
    pop_one();
    chk("res_empty_final", res_empty, 1'b1);

    // Three back-to-back pairs, one outstanding at a time
    push(32'h3FC0_0000, 32'h3FC0_0000);
    push(32'hBF80_0000, 32'h4000_0000);
    push(32'h0000_0000, 32'h4000_0000);
    serve(0, 1);
    chk("b2b_idle_gap", mif.in_valid, 1'b0);
    tick();
    chk("b2b_next_iv", mif.in_valid, 1'b1);
    serve(1, 0);
    serve(2, 2);
    repeat (3) pop_one();
    pop_one();

    // Overflow: DEPTH+1 pushes with the multiplier stalled
    for (int i = 0; i < DEPTH + 1; i++) push(32'h4100_0000 + i, 32'h3F80_0000 + i);
    chk("ovf_set", ovf, 1'b1);
    chk("op_full_set", op_full, 1'b1);
    for (int i = 0; i < DEPTH; i++) serve(0, 0);
    repeat (3) tick();
    chk("drain_no_iv", mif.in_valid, 1'b0);
    chk("drain_issued", issued_cnt, m_issued);

    // Result FIFO backpressure: 8 stored, 9th held until one pop
    push(32'h4000_0000, 32'h4040_0000);
    serve_issue(0);
    present();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_res_ready", mif.res_ready, 1'b0);
    end
    pop_one();
    chk("bp_release", mif.res_ready, 1'b1);
    wait_accept();
    for (int i = 0; i < DEPTH; i++) pop_one();
    chk("bp_empty", res_empty, 1'b1);

    // Protocol error in IDLE
    mif.res_valid  = 1'b1;
    mif.res_data_i = 32'hDEAD_BEEF;
    tick();
    mif.res_valid  = 1'b0;
    mif.res_data_i = '0;
    chk("proto_err", proto_err, 1'b1);
    chk("proto_res_empty", res_empty, 1'b1);
    chk("proto_done", done_cnt, m_done);

    // Reset in WAIT_RES with 2 queued operands and 1 stored result
    push(32'h3FC0_0000, 32'h3FC0_0000);
    serve(0, 0);
    push(32'h4000_0000, 32'h4040_0000);
    push(32'hBF80_0000, 32'h4000_0000);
    push(32'h0000_0000, 32'h4000_0000);
    serve_issue(0);
    rst = 1'b1;
    tick();
    check_reset_state();
    rst = 1'b0;
    q_issue.delete();
    q_res.delete();
    m_opcnt = 0; m_rescnt = 0; m_issued = '0; m_done = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_iv", mif.in_valid, 1'b0);
    end
    chk("post_rst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
